// File: rtl/nios2e_nios2_qsys_0_cpu_debug_scan_master_if.sv
// Command/response interface of the debug scan master.
// A host issues scan commands (IR code + DR payload) and collects the captured DR words.
//   cmd_valid/cmd_ready : command handshake, cmd_ir/cmd_data qualify cmd_valid
//   rsp_valid/rsp_ready : response handshake, rsp_data qualifies rsp_valid
// Modports:
//   master : the host that issues commands and consumes responses
//   slave  : the scan engine that accepts commands and produces responses
interface nios2e_nios2_qsys_0_cpu_debug_scan_master_if #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [SR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [SR_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/nios2e_nios2_qsys_0_cpu_debug_scan_master.sv
// Host-side virtual-JTAG scan master for the CPU debug slave.
// Takes one scan command (IR code + DR payload), walks the virtual state sequence
// UIR -> CDR -> SDR -> UDR while generating tck/tdi, and returns the DR word captured
// from tdo. All timing is derived from clk: one tck period ("slot") is 2*TCK_DIV clks,
// tck low in the first half and high in the second half.
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   cmd_bus (slave)     cmd_valid/cmd_ready/cmd_ir/cmd_data, rsp_valid/rsp_ready/rsp_data
//   vji_tck/vji_tdi     generated test clock and serial data to the slave
//   vji_tdo             serial data from the slave
//   vji_ir_in           IR value presented to the slave (holds its last value when idle)
//   vji_uir/cdr/sdr/udr one-hot virtual state strobes, each high for its whole slot
//   vji_rti             run-test/idle indicator (IDLE and RSP only)
//   busy                high in every state except IDLE
// Optional feature macro: DEBUG_SCAN_SKIP_IR_EN -- when defined, a scan whose IR equals
// the IR of the previous completed scan skips the UIR slot. The first scan after reset
// always performs UIR.
module nios2e_nios2_qsys_0_cpu_debug_scan_master #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    nios2e_nios2_qsys_0_cpu_debug_scan_master_if.slave cmd_bus,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic                busy
);

    // 9 bits covers a slot of up to 2*255 clks.
    localparam int CNT_W = 9;
    localparam int BIT_W = $clog2(SR_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RISE_CNT = CNT_W'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SR_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic [SR_WIDTH-1:0] sreg_r;
    logic [SR_WIDTH-1:0] rsp_data_r;
    logic [IR_WIDTH-1:0] ir_r;
    logic                cmd_ready_r;
    logic                rsp_valid_r;
    logic                tck_r;
    logic                tdi_r;
    logic                uir_r;
    logic                cdr_r;
    logic                sdr_r;
    logic                udr_r;
    logic                rti_r;
    logic                busy_r;
`ifdef DEBUG_SCAN_SKIP_IR_EN
    logic                last_ir_valid_r;
`endif

    logic rise_s;
    logic slot_end_s;
    logic in_scan_s;

    // Slot phase decode: tck rises when the low half ends, the slot ends after the high half.
    assign rise_s     = (cnt_r == RISE_CNT);
    assign slot_end_s = (cnt_r == LAST_CNT);
    assign in_scan_s  = (state_r == ST_UIR) || (state_r == ST_CDR) ||
                        (state_r == ST_SDR) || (state_r == ST_UDR);

    // Scan sequencer: state, slot timing, shift register and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            bit_cnt_r   <= {BIT_W{1'b0}};
            sreg_r      <= {SR_WIDTH{1'b0}};
            rsp_data_r  <= {SR_WIDTH{1'b0}};
            ir_r        <= {IR_WIDTH{1'b0}};
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            tck_r       <= 1'b0;
            tdi_r       <= 1'b0;
            uir_r       <= 1'b0;
            cdr_r       <= 1'b0;
            sdr_r       <= 1'b0;
            udr_r       <= 1'b0;
            rti_r       <= 1'b1;
            busy_r      <= 1'b0;
`ifdef DEBUG_SCAN_SKIP_IR_EN
            last_ir_valid_r <= 1'b0;
`endif
        end else begin
            // Common tck generation for every slot-timed state.
            if (in_scan_s) begin
                if (slot_end_s) begin
                    cnt_r <= {CNT_W{1'b0}};
                    tck_r <= 1'b0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (rise_s) begin
                        tck_r <= 1'b1;
                    end
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (cmd_bus.cmd_valid) begin
                        ir_r        <= cmd_bus.cmd_ir;
                        sreg_r      <= cmd_bus.cmd_data;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        rti_r       <= 1'b0;
                        cnt_r       <= {CNT_W{1'b0}};
                        tck_r       <= 1'b0;
                        bit_cnt_r   <= {BIT_W{1'b0}};
`ifdef DEBUG_SCAN_SKIP_IR_EN
                        if (last_ir_valid_r && (cmd_bus.cmd_ir == ir_r)) begin
                            state_r <= ST_CDR;
                            cdr_r   <= 1'b1;
                        end else begin
                            state_r <= ST_UIR;
                            uir_r   <= 1'b1;
                        end
`else
                        state_r <= ST_UIR;
                        uir_r   <= 1'b1;
`endif
                    end
                end
                ST_UIR: begin
                    if (slot_end_s) begin
                        state_r <= ST_CDR;
                        uir_r   <= 1'b0;
                        cdr_r   <= 1'b1;
                    end
                end
                ST_CDR: begin
                    if (slot_end_s) begin
                        state_r   <= ST_SDR;
                        cdr_r     <= 1'b0;
                        sdr_r     <= 1'b1;
                        tdi_r     <= sreg_r[0];
                        bit_cnt_r <= {BIT_W{1'b0}};
                    end
                end
                ST_SDR: begin
                    // Capture tdo on the edge where tck rises; tdi moves on at slot start.
                    if (rise_s) begin
                        sreg_r <= {vji_tdo, sreg_r[SR_WIDTH-1:1]};
                    end
                    if (slot_end_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= ST_UDR;
                            sdr_r   <= 1'b0;
                            udr_r   <= 1'b1;
                            tdi_r   <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                            tdi_r     <= sreg_r[0];
                        end
                    end
                end
                ST_UDR: begin
                    if (slot_end_s) begin
                        state_r     <= ST_RSP;
                        udr_r       <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= sreg_r;
                        rti_r       <= 1'b1;
                    end
                end
                ST_RSP: begin
                    if (cmd_bus.rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
`ifdef DEBUG_SCAN_SKIP_IR_EN
                        last_ir_valid_r <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    tck_r       <= 1'b0;
                    tdi_r       <= 1'b0;
                    uir_r       <= 1'b0;
                    cdr_r       <= 1'b0;
                    sdr_r       <= 1'b0;
                    udr_r       <= 1'b0;
                    rti_r       <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_bus.cmd_ready = cmd_ready_r;
    assign cmd_bus.rsp_valid = rsp_valid_r;
    assign cmd_bus.rsp_data  = rsp_data_r;
    assign vji_tck           = tck_r;
    assign vji_tdi           = tdi_r;
    assign vji_ir_in         = ir_r;
    assign vji_uir           = uir_r;
    assign vji_cdr           = cdr_r;
    assign vji_sdr           = sdr_r;
    assign vji_udr           = udr_r;
    assign vji_rti           = rti_r;
    assign busy              = busy_r;

endmodule

// File: tb/tb_nios2e_nios2_qsys_0_cpu_debug_scan_master.sv
// Scoreboard bench for the debug scan master. The driver pushes the expected response
// (captured word, latency, UIR width) when a command is accepted; a separate monitor
// compares when the DUT presents a response. The slave side is modelled as either a
// tdi->tdo loopback or a fixed tdo bit pattern, so the captured word is the payload or
// the pattern respectively.
module tb_nios2e_nios2_qsys_0_cpu_debug_scan_master;

    localparam int SR_WIDTH = 38;
    localparam int IR_WIDTH = 2;
    localparam int TCK_DIV  = 2;
    localparam int SLOT     = 2 * TCK_DIV;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios2e_nios2_qsys_0_cpu_debug_scan_master_if #(.SR_WIDTH(SR_WIDTH), .IR_WIDTH(IR_WIDTH)) bus ();

    logic                vji_tck, vji_tdi, vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic                vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, busy;

    nios2e_nios2_qsys_0_cpu_debug_scan_master #(
        .SR_WIDTH(SR_WIDTH), .IR_WIDTH(IR_WIDTH), .TCK_DIV(TCK_DIV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_bus(bus),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti), .busy(busy)
    );

    typedef struct {
        logic [SR_WIDTH-1:0] data;
        int                  lat;
        int                  uir;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_rises = 0;
    bit   held = 1'b0;
    bit   prev_ok = 1'b0;
    logic [IR_WIDTH-1:0] prev_ir = '0;
    bit                  tdo_mode = 1'b0;
    logic [SR_WIDTH-1:0] pat = '0;
    logic [SR_WIDTH-1:0] cur_data = '0;
    logic [6:0]          rise_idx = 7'd0;
    logic                pat_bit;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Slave model: loopback, or pattern bit k presented for the k-th SDR tck rise.
    always_comb pat_bit = (rise_idx < 7'd38) ? pat[rise_idx[5:0]] : 1'b0;
    assign vji_tdo = tdo_mode ? pat_bit : vji_tdi;

    always @(posedge clk) cyc <= cyc + 1;

    // Count SDR tck rises and check each tdi bit against the payload, LSB first.
    always @(posedge vji_tck) begin
        if (vji_sdr) begin
            if (rise_idx < 7'd38) check("tdi_bit", 64'(vji_tdi), 64'(cur_data[rise_idx[5:0]]));
            rise_idx <= rise_idx + 7'd1;
        end else begin
            if (vji_udr) last_rises <= int'(rise_idx);
            rise_idx <= 7'd0;
        end
    end

    // Response consumer: first response stalled 20 clks, later ones random.
    initial begin : rsp_side
        int w = 0;
        int stall = 0;
        int nrsp = 0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (w == 0) begin
                    stall = (nrsp == 0) ? 20 : $urandom_range(0, 25);
                    nrsp++;
                end
                bus.rsp_ready = (w >= stall);
                w++;
            end else begin
                w = 0;
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard compare on responses.
    initial begin : monitor
        int acc_cyc = 0;
        int pop_cyc = 0;
        int uir_len = 0;
        int cdr_len = 0;
        logic prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                prev_valid = 1'b0;
                uir_len = 0;
                cdr_len = 0;
            end else begin
                check("cmd_ready_vs_busy", 64'(bus.cmd_ready), 64'(!busy));
                check("rti", 64'(vji_rti), 64'(!busy || bus.rsp_valid));
                check("strobe_onehot", 64'($countones({vji_uir, vji_cdr, vji_sdr, vji_udr}) <= 1), 64'(1));
                if (!vji_sdr) check("tdi_outside_sdr", 64'(vji_tdi), 64'(0));
                if (vji_uir) uir_len++;
                if (vji_cdr) cdr_len++;
                if (bus.rsp_valid && !prev_valid) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at cycle %0d", cyc);
                    end else begin
                        check("latency", 64'(cyc - acc_cyc), 64'(sbq[0].lat));
                        check("uir_width", 64'(uir_len), 64'(sbq[0].uir));
                        check("cdr_width", 64'(cdr_len), 64'(SLOT));
                        check("sdr_rises", 64'(last_rises), 64'(SR_WIDTH));
                    end
                end
                if (bus.rsp_valid && (sbq.size() > 0)) begin
                    check("rsp_data", 64'(bus.rsp_data), 64'(sbq[0].data));
                end
                if (bus.rsp_valid && bus.rsp_ready && (sbq.size() > 0)) begin
                    void'(sbq.pop_front());
                    pop_cyc = cyc + 1;
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    acc_cyc = cyc + 1;
                    if (held) check("accept_after_rsp", 64'(acc_cyc - pop_cyc), 64'(1));
                    uir_len = 0;
                    cdr_len = 0;
                end
                prev_valid = bus.rsp_valid;
            end
        end
    end

    task automatic check_reset_values();
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
        check("rst_tck", 64'(vji_tck), 64'(0));
        check("rst_tdi", 64'(vji_tdi), 64'(0));
        check("rst_ir_in", 64'(vji_ir_in), 64'(0));
        check("rst_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'(0));
        check("rst_rti", 64'(vji_rti), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
    endtask

    // Issue one scan; cmd_valid is held (with junk fields) until the DUT is ready.
    task automatic issue(input logic [IR_WIDTH-1:0] ir, input logic [SR_WIDTH-1:0] data,
                         input bit mode, input logic [SR_WIDTH-1:0] p);
        int   n = 0;
        bit   skip = 1'b0;
        exp_t e;
        logic [63:0] junk;
        junk = {$urandom(), $urandom()};
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = junk[IR_WIDTH-1:0];
        bus.cmd_data  = junk[SR_WIDTH-1:0];
        held = 1'b0;
        while (!bus.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
            held = 1'b1;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 2000 cycles");
            bus.cmd_valid = 1'b0;
            return;
        end
        bus.cmd_ir   = ir;
        bus.cmd_data = data;
        tdo_mode     = mode;
        pat          = p;
        cur_data     = data;
`ifdef DEBUG_SCAN_SKIP_IR_EN
        skip = prev_ok && (ir == prev_ir);
`endif
        e.data = mode ? p : data;
        e.lat  = (SR_WIDTH + 3) * SLOT - (skip ? SLOT : 0);
        e.uir  = skip ? 0 : SLOT;
        sbq.push_back(e);
        prev_ok = 1'b1;
        prev_ir = ir;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [63:0] r1;
        logic [63:0] r2;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_ir    = '0;
        bus.cmd_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values();

        // Loopback with the reference payload; its response is stalled 20 clks while
        // the next command is held on cmd_valid.
        issue(2'b01, 38'h2_AAAA_5555, 1'b0, 38'h0);
        check("ir_in_latched", 64'(vji_ir_in), 64'(2'b01));
        // tdo tied high.
        r1 = {$urandom(), $urandom()};
        issue(2'b11, r1[SR_WIDTH-1:0], 1'b1, 38'h3F_FFFF_FFFF);
        // Two scans with the same IR (UIR skipped on the second when enabled).
        r1 = {$urandom(), $urandom()};
        issue(2'b10, r1[SR_WIDTH-1:0], 1'b0, 38'h0);
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        issue(2'b10, r1[SR_WIDTH-1:0], 1'b1, r2[SR_WIDTH-1:0]);

        // Abort during SDR slot 17.
        r1 = {$urandom(), $urandom()};
        issue(2'b01, r1[SR_WIDTH-1:0], 1'b0, 38'h0);
        n = 0;
        while (!(vji_sdr && rise_idx == 7'd17) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_sdr_slot17", 64'(n < 1000), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        sbq.delete();
        prev_ok = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        r1 = {$urandom(), $urandom()};
        issue(2'b01, r1[SR_WIDTH-1:0], 1'b0, 38'h0);

        // Random scans.
        for (int i = 0; i < 12; i++) begin
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            issue(IR_WIDTH'($urandom_range(0, 3)), r1[SR_WIDTH-1:0], 1'($urandom_range(0, 1)),
                  r2[SR_WIDTH-1:0]);
        end

        n = 0;
        while (sbq.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_responses", 64'(sbq.size()), 64'(0));
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
